multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUCTL_W, default 4, SHALL set ALUControl width (minimum 4).
REQ-002 Parameter MEM_TIMEOUT, default 0, SHALL set the maximum wait cycles for mem_ready; 0 disables the timeout.
REQ-003 Ports (clock and reset first):
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- op  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero, Lt, Ltu  in  1 each  ALU compare flags from the SUB result
- mem_ready  in  1  memory completes the current access
- mem_req  out  1  memory access request
- MemWrite  out  1  store strobe
- IRWrite  out  1  instruction register load
- PCWrite  out  1  PC update
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- ALUSrcA, ALUSrcB  out  2 each  ALU operand selects
- ResultSrc  out  2  result select
- RegWrite  out  1  register file write
- ImmSrc  out  3  I/S/B/U/J immediate select
- ALUControl  out  ALUCTL_W  ALU operation
- illegal_op  out  1  sticky fault flag
- busy  out  1  high in every state except FETCH-idle

Function
REQ-004 FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, FAULT.
REQ-005 FETCH SHALL assert mem_req with AdrSrc=0 until mem_ready is high; on that cycle it SHALL assert IRWrite and PCWrite (PC+4), then go to DECODE.
REQ-006 DECODE SHALL take exactly 1 cycle and branch by op: load/store->MEMADR; R->EXECR; I-ALU->EXECI; branch->BRANCH; jal->JAL; jalr->JALR; lui/auipc->UPPER; any other->FAULT.
REQ-007 MEMADR->MEMRD (load) or MEMWR (store); MEMRD->MEMWB after mem_ready; MEMWR SHALL hold MemWrite and mem_req until mem_ready, then go to FETCH.
REQ-008 Each mem_req SHALL stay high with stable AdrSrc and MemWrite until the mem_ready cycle, and SHALL deassert on the cycle after it.
REQ-009 EXECR and EXECI SHALL go to ALUWB; ALUWB, MEMWB, JAL, JALR and UPPER SHALL pulse RegWrite for 1 cycle, then go to FETCH.
REQ-010 BRANCH SHALL evaluate beq/bne/blt/bge/bltu/bgeu from Zero, Lt and Ltu, and SHALL assert PCWrite only when taken; funct3 010/011 SHALL go to FAULT.
REQ-011 Instruction latencies with mem_ready always high SHALL be: load 5, store 4, R/I/jal/jalr/upper 4, branch 3 cycles.
REQ-012 ALUControl SHALL encode add, sub, and, or, xor, sll, srl, sra, slt, sltu; funct7b5 SHALL select sub only when op[5]=1, and SHALL select sra for shifts.
REQ-013 FAULT SHALL set illegal_op, SHALL hold all write enables and mem_req low, and SHALL be left only by reset.
REQ-014 If MEM_TIMEOUT>0 and mem_ready stays low for MEM_TIMEOUT consecutive request cycles, the FSM SHALL enter FAULT; the counter SHALL clear on every mem_ready.

Reset
REQ-015 While rst_n is low: state=FETCH, all strobes 0, mem_req=0, illegal_op=0, ALUControl=0, counters=0.
REQ-016 Reset asserted mid-access SHALL abandon the access immediately; after release, the first mem_req SHALL appear 1 cycle later.

Configuration
REQ-017 When PERF_CNT_EN is defined, the block SHALL add 32-bit outputs cycle_cnt (increments every non-reset cycle, wraps 0xFFFFFFFF->0) and instret_cnt (increments on each return to FETCH from a completing state, wraps). Without the macro, these ports and the logic behind them SHALL be absent.

Structure
REQ-018 Package mc_pkg SHALL hold the state enum, opcode constants, ALUOp encoding and ALUControl codes.
REQ-019 ALU decoding SHALL be done in a combinational sub-module mc_alu_decode.

Verification
REQ-020 add x1,x2,x3 (op 0110011, funct3 000) with mem_ready=1 -> RegWrite pulses in cycle 4, ALUControl=add, back in FETCH in cycle 5.
REQ-021 lw with mem_ready delayed 3 cycles in MEMRD -> mem_req held 4 cycles, RegWrite 1 cycle later, ResultSrc=data.
REQ-022 bne with Zero=1 -> PCWrite=0 in BRANCH; with Zero=0 -> PCWrite=1; both cases take 3 cycles.
REQ-023 op=0000000 -> illegal_op=1 after DECODE, stays 1 for 100 cycles; rst_n low clears it.
REQ-024 MEM_TIMEOUT=8 with mem_ready stuck low in FETCH -> FAULT entered on cycle 8.
REQ-025 PERF_CNT_EN defined, 10 back-to-back addi -> instret_cnt=10 and cycle_cnt=40.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multicycle controller.
//   - state_t      controller FSM states
//   - OP_*         RV32I major opcodes recognised by DECODE
//   - ALUOP_*      coarse ALU operation class handed to mc_alu_decode
//   - ALU_*        4-bit ALUControl codes (ADD is 0 so the reset value reads as add)
//   - IMM_*        ImmSrc codes and imm_sel() helper
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR,
      EXECI, ALUWB, BRANCH, JAL, JALR, UPPER, FAULT
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   function automatic logic [2:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_STORE:         imm_sel = IMM_S;
         OP_BRANCH:        imm_sel = IMM_B;
         OP_LUI, OP_AUIPC: imm_sel = IMM_U;
         OP_JAL:           imm_sel = IMM_J;
         default:          imm_sel = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: combinational ALU operation decoder.
// Ports:
//   i_aluop     operation class (ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT)
//   i_funct3    instruction funct3
//   i_funct7b5  instruction bit 30
//   i_op5       opcode bit 5 (1 = register-register form)
//   o_alu_ctl   4-bit ALU_* code
module mc_alu_decode
   import mc_pkg::*;
(
   input  logic [1:0] i_aluop,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_op5,
   output logic [3:0] o_alu_ctl
);

   always_comb begin
      o_alu_ctl = ALU_ADD;
      case (i_aluop)
         ALUOP_SUB:   o_alu_ctl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               // bit 30 is part of the immediate for addi, so only R-type may subtract
               3'b000:  o_alu_ctl = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b001:  o_alu_ctl = ALU_SLL;
               3'b010:  o_alu_ctl = ALU_SLT;
               3'b011:  o_alu_ctl = ALU_SLTU;
               3'b100:  o_alu_ctl = ALU_XOR;
               3'b101:  o_alu_ctl = i_funct7b5 ? ALU_SRA : ALU_SRL;
               3'b110:  o_alu_ctl = ALU_OR;
               default: o_alu_ctl = ALU_AND;
            endcase
         end
         default:     o_alu_ctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle control FSM.
// Optional feature macro: PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
// Inputs : clk, rst_n (async, active-low), op, funct3, funct7b5,
//          Zero/Lt/Ltu (SUB compare flags), mem_ready
// Outputs: mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
//          ResultSrc, RegWrite, ImmSrc, ALUControl, illegal_op, busy
// Selects: ALUSrcA 00=PC 01=OldPC 10=rs1 11=zero; ALUSrcB 00=rs2 01=imm 10=4;
//          ResultSrc 00=ALUOut 01=mem data 10=ALU result.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+=4 on mem_ready
// DECODE | pick path by opcode, precompute branch/jal target
// MEMADR | rs1+imm address
// MEMRD  | load access, wait mem_ready
// MEMWB  | write load data to rd
// MEMWR  | store access, wait mem_ready
// EXECR  | R-type ALU op
// EXECI  | I-type ALU op
// ALUWB  | write ALU result to rd
// BRANCH | compare, PCWrite when taken
// JAL    | phase0 PC=target, phase1 rd=PC+4
// JALR   | phase0 PC=rs1+imm, phase1 rd=PC+4
// UPPER  | phase0 compute lui/auipc, phase1 rd write
// FAULT  | illegal opcode or memory timeout, left only by reset
module multicycle_controller
   import mc_pkg::*;
#(
   parameter int ALUCTL_W    = 4,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          op,
   input  logic [2:0]          funct3,
   input  logic                funct7b5,
   input  logic                Zero,
   input  logic                Lt,
   input  logic                Ltu,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                PCWrite,
   output logic                AdrSrc,
   output logic [1:0]          ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ResultSrc,
   output logic                RegWrite,
   output logic [2:0]          ImmSrc,
   output logic [ALUCTL_W-1:0] ALUControl,
   output logic                illegal_op,
   output logic                busy
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]         cycle_cnt,
   output logic [31:0]         instret_cnt
`endif
);

   state_t      r_state, w_next;
   logic        r_run;
   logic        r_phase;
   logic [15:0] r_wait;
   logic        w_req, w_timeout, w_taken, w_branch_bad;
   logic [1:0]  w_aluop;
   logic [3:0]  w_alu_code;

   // r_run holds off the first request one cycle after reset release
   assign w_req = r_run && (r_state == FETCH || r_state == MEMRD || r_state == MEMWR);
   assign w_timeout = (MEM_TIMEOUT > 0) && w_req && !mem_ready &&
                      (r_wait == 16'(MEM_TIMEOUT - 1));

   always_comb begin
      w_taken      = 1'b0;
      w_branch_bad = 1'b0;
      case (funct3)
         3'b000:  w_taken = Zero;
         3'b001:  w_taken = !Zero;
         3'b100:  w_taken = Lt;
         3'b101:  w_taken = !Lt;
         3'b110:  w_taken = Ltu;
         3'b111:  w_taken = !Ltu;
         default: w_branch_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= FETCH;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run   <= 1'b0;
         r_phase <= 1'b0;
         r_wait  <= '0;
      end else begin
         r_run   <= 1'b1;
         r_phase <= (r_state == JAL || r_state == JALR || r_state == UPPER) && !r_phase;
         r_wait  <= (w_req && !mem_ready) ? r_wait + 16'd1 : 16'd0;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH:  if (w_req && mem_ready) w_next = DECODE;
         DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: w_next = MEMADR;
               OP_R:              w_next = EXECR;
               OP_I:              w_next = EXECI;
               OP_BRANCH:         w_next = BRANCH;
               OP_JAL:            w_next = JAL;
               OP_JALR:           w_next = JALR;
               OP_LUI, OP_AUIPC:  w_next = UPPER;
               default:           w_next = FAULT;
            endcase
         end
         MEMADR:            w_next = (op == OP_STORE) ? MEMWR : MEMRD;
         MEMRD:             if (mem_ready) w_next = MEMWB;
         MEMWR:             if (mem_ready) w_next = FETCH;
         EXECR, EXECI:      w_next = ALUWB;
         MEMWB, ALUWB:      w_next = FETCH;
         BRANCH:            w_next = w_branch_bad ? FAULT : FETCH;
         JAL, JALR, UPPER:  if (r_phase) w_next = FETCH;
         FAULT:             w_next = FAULT;
         default:           w_next = FAULT;
      endcase
      if (w_timeout) w_next = FAULT;
   end

   always_comb begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      RegWrite   = 1'b0;
      w_aluop    = ALUOP_ADD;
      ImmSrc     = imm_sel(op);
      illegal_op = (r_state == FAULT);
      busy       = (r_state != FETCH);
      case (r_state)
         FETCH: begin
            mem_req   = w_req;
            IRWrite   = w_req && mem_ready;
            PCWrite   = w_req && mem_ready;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         MEMRD: begin
            mem_req = w_req;
            AdrSrc  = 1'b1;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         MEMWR: begin
            mem_req  = w_req;
            MemWrite = w_req;
            AdrSrc   = 1'b1;
         end
         EXECR: begin
            ALUSrcA = 2'b10;
            w_aluop = ALUOP_FUNCT;
         end
         EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            w_aluop = ALUOP_FUNCT;
         end
         ALUWB:  RegWrite = 1'b1;
         BRANCH: begin
            ALUSrcA = 2'b10;
            w_aluop = ALUOP_SUB;
            PCWrite = w_taken && !w_branch_bad;
         end
         JAL: begin
            // ALUOut still holds the target from DECODE while PC+4 is formed
            if (!r_phase) begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               PCWrite = 1'b1;
            end else begin
               RegWrite = 1'b1;
            end
         end
         JALR: begin
            ResultSrc = 2'b10;
            if (!r_phase) begin
               ALUSrcA = 2'b10;
               ALUSrcB = 2'b01;
               PCWrite = 1'b1;
            end else begin
               ALUSrcA  = 2'b01;
               ALUSrcB  = 2'b10;
               RegWrite = 1'b1;
            end
         end
         UPPER: begin
            if (!r_phase) begin
               ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
               ALUSrcB = 2'b01;
            end else begin
               RegWrite = 1'b1;
            end
         end
         default: ;
      endcase
   end

   mc_alu_decode u_alu_decode (
      .i_aluop    (w_aluop),
      .i_funct3   (funct3),
      .i_funct7b5 (funct7b5),
      .i_op5      (op[5]),
      .o_alu_ctl  (w_alu_code)
   );

   assign ALUControl = ALUCTL_W'(w_alu_code);

`ifdef PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (r_run) cycle_cnt <= cycle_cnt + 32'd1;
         if (r_state != FETCH && r_state != FAULT && w_next == FETCH)
            instret_cnt <= instret_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller (built with MEM_TIMEOUT=8).
// Table-driven instruction vectors plus hand-written multi-cycle sequences.
module tb_multicycle_controller;

   localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYP = 7'b0110011,
                          ITYP = 7'b0010011, BR = 7'b1100011, JALO = 7'b1101111,
                          JALRO = 7'b1100111, LUIO = 7'b0110111, AUIPCO = 7'b0010111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [6:0] op = '0;
   logic [2:0] funct3 = '0;
   logic funct7b5 = 1'b0, Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0, mem_ready = 1'b0;
   logic mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, illegal_op, busy;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl;
`ifdef PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.ALUCTL_W(4), .MEM_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .illegal_op(illegal_op), .busy(busy)
`ifdef PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z, lt, ltu;
      int         lat;      // cycles FETCH..last state
      int         rw;       // RegWrite pulses
      logic       chk_alu;
      logic [3:0] alu;      // ALUControl in cycle 3
      logic       chk_pcw;
      logic       pcw;      // PCWrite in cycle 3
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // leaves the bench in the first running FETCH cycle (mem_req high)
   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("post_release_no_req", mem_req, 0);
      step();
   endtask

   task automatic addv(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic lt, input logic ltu, input int lat,
                       input int rw, input logic ca, input logic [3:0] alu,
                       input logic cp, input logic pcw);
      vec_t v;
      v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.ltu = ltu;
      v.lat = lat; v.rw = rw; v.chk_alu = ca; v.alu = alu; v.chk_pcw = cp; v.pcw = pcw;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int cyc;
      int rw;
      logic [3:0] alu3;
      logic pcw3;
      op = v.op; funct3 = v.f3; funct7b5 = v.f7;
      Zero = v.z; Lt = v.lt; Ltu = v.ltu; mem_ready = 1'b1;
      #1;
      cyc = 1;
      rw = int'(RegWrite);
      alu3 = 4'hx;
      pcw3 = 1'bx;
      step();
      while (busy && cyc < 20) begin
         cyc++;
         if (cyc == 3) begin
            alu3 = ALUControl;
            pcw3 = PCWrite;
         end
         rw += int'(RegWrite);
         step();
      end
      chk($sformatf("vec%0d_latency", idx), cyc, v.lat);
      chk($sformatf("vec%0d_regwrite_pulses", idx), rw, v.rw);
      if (v.chk_alu) chk($sformatf("vec%0d_alucontrol", idx), alu3, v.alu);
      if (v.chk_pcw) chk($sformatf("vec%0d_pcwrite", idx), pcw3, v.pcw);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // op, f3, f7, Z, Lt, Ltu, lat, rw, chk_alu, alu, chk_pcw, pcw
      addv(RTYP,  3'b000, 0, 0, 0, 0, 4, 1, 1, 4'd0, 0, 0); // add
      addv(RTYP,  3'b000, 1, 0, 0, 0, 4, 1, 1, 4'd1, 0, 0); // sub
      addv(ITYP,  3'b000, 1, 0, 0, 0, 4, 1, 1, 4'd0, 0, 0); // addi, bit30 is imm
      addv(RTYP,  3'b101, 1, 0, 0, 0, 4, 1, 1, 4'd7, 0, 0); // sra
      addv(ITYP,  3'b101, 1, 0, 0, 0, 4, 1, 1, 4'd7, 0, 0); // srai
      addv(ITYP,  3'b101, 0, 0, 0, 0, 4, 1, 1, 4'd6, 0, 0); // srli
      addv(RTYP,  3'b001, 0, 0, 0, 0, 4, 1, 1, 4'd5, 0, 0); // sll
      addv(ITYP,  3'b010, 0, 0, 0, 0, 4, 1, 1, 4'd8, 0, 0); // slti
      addv(RTYP,  3'b011, 0, 0, 0, 0, 4, 1, 1, 4'd9, 0, 0); // sltu
      addv(ITYP,  3'b100, 0, 0, 0, 0, 4, 1, 1, 4'd4, 0, 0); // xori
      addv(RTYP,  3'b110, 0, 0, 0, 0, 4, 1, 1, 4'd3, 0, 0); // or
      addv(RTYP,  3'b111, 0, 0, 0, 0, 4, 1, 1, 4'd2, 0, 0); // and
      addv(LOAD,  3'b010, 0, 0, 0, 0, 5, 1, 0, 4'd0, 0, 0); // lw
      addv(STORE, 3'b010, 0, 0, 0, 0, 4, 0, 0, 4'd0, 0, 0); // sw
      addv(BR,    3'b000, 0, 1, 0, 0, 3, 0, 1, 4'd1, 1, 1); // beq taken
      addv(BR,    3'b000, 0, 0, 0, 0, 3, 0, 1, 4'd1, 1, 0); // beq not taken
      addv(BR,    3'b001, 0, 1, 0, 0, 3, 0, 0, 4'd0, 1, 0); // bne Zero=1
      addv(BR,    3'b001, 0, 0, 0, 0, 3, 0, 0, 4'd0, 1, 1); // bne Zero=0
      addv(BR,    3'b100, 0, 0, 1, 0, 3, 0, 0, 4'd0, 1, 1); // blt
      addv(BR,    3'b101, 0, 0, 1, 0, 3, 0, 0, 4'd0, 1, 0); // bge
      addv(BR,    3'b110, 0, 0, 0, 0, 3, 0, 0, 4'd0, 1, 0); // bltu
      addv(BR,    3'b111, 0, 0, 0, 0, 3, 0, 0, 4'd0, 1, 1); // bgeu
      addv(JALO,  3'b000, 0, 0, 0, 0, 4, 1, 0, 4'd0, 0, 0);
      addv(JALRO, 3'b000, 0, 0, 0, 0, 4, 1, 0, 4'd0, 0, 0);
      addv(LUIO,  3'b000, 0, 0, 0, 0, 4, 1, 0, 4'd0, 0, 0);
      addv(AUIPCO,3'b000, 0, 0, 0, 0, 4, 1, 0, 4'd0, 0, 0);

      // reset values while rst_n is low
      rst_n = 1'b0;
      mem_ready = 1'b1;
      step();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_strobes", {MemWrite, IRWrite, PCWrite, RegWrite}, 4'b0000);
      chk("rst_illegal_op", illegal_op, 0);
      chk("rst_alucontrol", ALUControl, 0);
      chk("rst_busy", busy, 0);
      do_reset();
      chk("first_fetch_req", mem_req, 1);
      chk("first_fetch_adrsrc", AdrSrc, 0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // FETCH waits for mem_ready
      do_reset();
      op = RTYP; funct3 = 3'b000; funct7b5 = 1'b0;
      mem_ready = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("fetch_wait_req", mem_req, 1);
         chk("fetch_wait_irwrite", IRWrite, 0);
         step();
      end
      mem_ready = 1'b1;
      #1;
      chk("fetch_done_ir_pc", {IRWrite, PCWrite, AdrSrc}, 3'b110);
      step();
      chk("decode_no_req", {mem_req, busy}, 2'b01);

      // lw with 3 wait cycles in MEMRD
      do_reset();
      op = LOAD; funct3 = 3'b010;
      step(); step(); step();
      mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) mem_ready = 1'b1;
         #1;
         chk($sformatf("lw_memrd_req%0d", k), {mem_req, AdrSrc, MemWrite}, 3'b110);
         step();
      end
      chk("lw_memwb_regwrite", RegWrite, 1);
      chk("lw_memwb_resultsrc", ResultSrc, 2'b01);
      chk("lw_memwb_req_low", mem_req, 0);
      step();
      chk("lw_back_fetch", {busy, RegWrite}, 2'b00);

      // store waits 4 cycles, then fetch waits 5: the counter must clear between them
      do_reset();
      op = STORE; funct3 = 3'b010;
      step(); step(); step();
      mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("sw_memwr_hold", {mem_req, MemWrite, AdrSrc}, 3'b111);
         step();
      end
      mem_ready = 1'b1;
      #1;
      chk("sw_memwr_ready", MemWrite, 1);
      step();
      chk("sw_back_fetch", {busy, MemWrite}, 2'b00);
      mem_ready = 1'b0;
      repeat (5) step();
      mem_ready = 1'b1;
      #1;
      step();
      chk("timeout_counter_cleared", {illegal_op, busy}, 2'b01);

      // mem_ready low for 7 request cycles is tolerated, the 8th times out
      do_reset();
      op = RTYP;
      mem_ready = 1'b0;
      repeat (7) step();
      chk("timeout_cycle8_still_fetch", {illegal_op, mem_req}, 2'b01);
      step();
      chk("timeout_fault", {illegal_op, mem_req}, 2'b10);

      // reset in the middle of a load abandons the access
      do_reset();
      op = LOAD;
      step(); step(); step();
      mem_ready = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      chk("midreset_req_drop", {mem_req, busy}, 2'b00);
      step();
      rst_n = 1'b1;
      #1;
      chk("midreset_release_no_req", mem_req, 0);
      step();
      chk("midreset_req_next_cycle", mem_req, 1);

      // illegal opcode: sticky fault, no strobes
      do_reset();
      op = 7'b0000000;
      step(); step();
      chk("illegal_after_decode", illegal_op, 1);
      for (int k = 0; k < 100; k++) begin
         chk("illegal_sticky", {illegal_op, mem_req, MemWrite, IRWrite, PCWrite, RegWrite},
             6'b100000);
         step();
      end
      rst_n = 1'b0;
      #1;
      chk("illegal_cleared_by_reset", illegal_op, 0);

      // branch with reserved funct3
      do_reset();
      op = BR; funct3 = 3'b010; Zero = 1'b1;
      step(); step();
      chk("branch_bad_pcwrite", PCWrite, 0);
      step();
      chk("branch_bad_fault", illegal_op, 1);

`ifdef PERF_CNT_EN
      do_reset();
      op = ITYP; funct3 = 3'b000; funct7b5 = 1'b0;
      repeat (40) step();
      chk("perf_instret", instret_cnt, 10);
      chk("perf_cycle", cycle_cnt, 40);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
